// File: rtl/fcp_burst_master.sv
// Frame master for a LANES-wide serial bus: header, acked write or read burst, end marker.
// Header acks time out and retry; the end ack times out without retry.
module fcp_burst_master #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned MAX_BURST   = 8,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       header_in,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [LANES-1:0] data_out,
  output logic             data_oe,
  input  logic [LANES-1:0] data_in,
  output logic [1:0]       ctrl,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_code
);

  localparam int unsigned B  = 8 / LANES;
  localparam int unsigned SW = (B > 1) ? $clog2(B) : 1;
  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StHdr      = 3'd1;
  localparam logic [2:0] StWaitHack = 3'd2;
  localparam logic [2:0] StWdata    = 3'd3;
  localparam logic [2:0] StRdata    = 3'd4;
  localparam logic [2:0] StEnd      = 3'd5;
  localparam logic [2:0] StWaitDack = 3'd6;
  localparam logic [2:0] StFin      = 3'd7;

  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpRead  = 2'b10;

  logic [2:0]    state_q, state_d;
  logic [7:0]    hdr_q, hdr_d;
  logic [7:0]    shift_q, shift_d;
  logic [SW-1:0] slice_q, slice_d;
  logic [3:0]    byte_q, byte_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          have_q, have_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic [3:0]    req_len;
  logic [7:0]    rd_next;
  logic          last_slice;
  logic          last_byte;
  logic          timer_end;

  assign req_len    = {1'b0, header_in[2:0]} + 4'd1;
  assign last_slice = (slice_q == SW'(B - 1));
  assign last_byte  = (byte_q == {1'b0, hdr_q[2:0]});
  assign timer_end  = (timer_q == TW'(ACK_TIMEOUT - 1));

  always_comb begin
    rd_next = shift_q << LANES;
    rd_next[LANES-1:0] = data_in;
  end

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    shift_d    = shift_q;
    slice_d    = slice_q;
    byte_d     = byte_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    have_d     = have_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          hdr_d      = header_in;
          err_code_d = 2'b00;
          if (header_in[7:6] != OpWrite && header_in[7:6] != OpRead) begin
            state_d    = StFin;
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end else if ({28'd0, req_len} > MAX_BURST) begin
            state_d    = StFin;
            err_d      = 1'b1;
            err_code_d = 2'b10;
          end else begin
            state_d = StHdr;
            shift_d = header_in;
            slice_d = '0;
            retry_d = '0;
          end
        end
      end

      StHdr: begin
        shift_d = shift_q << LANES;
        slice_d = slice_q + 1'b1;
        if (last_slice) begin
          state_d = StWaitHack;
          slice_d = '0;
          timer_d = '0;
        end
      end

      StWaitHack: begin
        timer_d = timer_q + 1'b1;
        // An ack on the final cycle of the window still wins over the timeout.
        if (ack) begin
          byte_d  = '0;
          slice_d = '0;
          have_d  = 1'b0;
          state_d = (hdr_q[7:6] == OpWrite) ? StWdata : StRdata;
        end else if (timer_end) begin
          if (retry_q == RW'(MAX_RETRY)) begin
            state_d    = StFin;
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = StHdr;
            shift_d = hdr_q;
            slice_d = '0;
          end
        end
      end

      StWdata: begin
        if (!have_q) begin
          if (wr_valid) begin
            shift_d = wr_data;
            have_d  = 1'b1;
            slice_d = '0;
          end
        end else begin
          shift_d = shift_q << LANES;
          slice_d = slice_q + 1'b1;
          if (last_slice) begin
            slice_d = '0;
            have_d  = 1'b0;
            byte_d  = byte_q + 1'b1;
            if (last_byte) state_d = StEnd;
          end
        end
      end

      StRdata: begin
        shift_d = rd_next;
        slice_d = slice_q + 1'b1;
        if (last_slice) begin
          slice_d    = '0;
          rd_valid_d = 1'b1;
          rd_data_d  = rd_next;
          byte_d     = byte_q + 1'b1;
          if (last_byte) state_d = StEnd;
        end
      end

      StEnd: begin
        state_d = StWaitDack;
        timer_d = '0;
      end

      StWaitDack: begin
        timer_d = timer_q + 1'b1;
        if (ack) begin
          state_d = StFin;
          err_d   = 1'b0;
        end else if (timer_end) begin
          state_d    = StFin;
          err_d      = 1'b1;
          err_code_d = 2'b01;
        end
      end

      StFin: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      hdr_q      <= '0;
      shift_q    <= '0;
      slice_q    <= '0;
      byte_q     <= '0;
      retry_q    <= '0;
      timer_q    <= '0;
      have_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      shift_q    <= shift_d;
      slice_q    <= slice_d;
      byte_q     <= byte_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      have_q     <= have_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  always_comb begin
    ctrl     = 2'b00;
    data_oe  = 1'b0;
    data_out = '0;
    wr_ready = 1'b0;
    case (state_q)
      StHdr: begin
        ctrl     = 2'b01;
        data_oe  = 1'b1;
        data_out = shift_q[7 -: LANES];
      end
      StWdata: begin
        // Without a loaded byte this is a byte boundary: idle the bus until data arrives.
        if (have_q) begin
          ctrl     = 2'b10;
          data_oe  = 1'b1;
          data_out = shift_q[7 -: LANES];
        end else begin
          wr_ready = wr_valid;
        end
      end
      StRdata: ctrl = 2'b10;
      StEnd:   ctrl = 2'b11;
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StFin) && !err_q;
  assign error    = (state_q == StFin) && err_q;
  assign err_code = err_code_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_fcp_burst_master.sv
// Randomized and directed frames for fcp_burst_master, checked against a frame-level model
// that predicts header count, payload bytes and the final outcome from the header and ack delays.
module tb_fcp_burst_master;

  localparam int LANES       = 2;
  localparam int MAX_BURST   = 4;
  localparam int ACK_TIMEOUT = 6;
  localparam int MAX_RETRY   = 3;
  localparam int B           = 8 / LANES;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [7:0]       header_in = '0;
  logic [7:0]       wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [LANES-1:0] data_out;
  logic             data_oe;
  logic [LANES-1:0] data_in = '0;
  logic [1:0]       ctrl;
  logic             ack = 1'b0;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-frame stimulus: write source bytes, slave read bytes, ack delay per header attempt.
  logic [7:0] wr_q[$];
  logic [7:0] rd_src[$];
  int         hack_dly[MAX_RETRY+2];
  int         dack_dly;
  int         gap_byte;
  int         gap_len;
  bit         rand_gap;
  bit         spur;

  always #5 clk = ~clk;

  fcp_burst_master #(
    .LANES      (LANES),
    .MAX_BURST  (MAX_BURST),
    .ACK_TIMEOUT(ACK_TIMEOUT),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .header_in(header_in),
    .wr_data  (wr_data),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .data_out (data_out),
    .data_oe  (data_oe),
    .data_in  (data_in),
    .ctrl     (ctrl),
    .ack      (ack),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_code (err_code)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setup(input int hd, input int dd);
    for (int i = 0; i < MAX_RETRY + 2; i++) hack_dly[i] = hd;
    dack_dly = dd;
    gap_byte = -1;
    gap_len  = 0;
    rand_gap = 1'b0;
    spur     = 1'b0;
    wr_q.delete();
    rd_src.delete();
    for (int i = 0; i < 8; i++) begin
      wr_q.push_back(8'($urandom));
      rd_src.push_back(8'($urandom));
    end
  endtask

  function automatic int rand_dly();
    if ($urandom_range(0, 3) == 0) return $urandom_range(ACK_TIMEOUT, ACK_TIMEOUT + 3);
    return $urandom_range(0, ACK_TIMEOUT - 1);
  endfunction

  task automatic run_frame(input logic [7:0] h, input bit rst_in_read, output int stalls);
    int op, len, d, attempt, in_wait, wait_idx, rs, wr_idx, hold;
    int hdr_run, hdr_count, hdr_bad, ready_cnt, ready_bad, end_count, bus_act;
    int oe_bad, idle_bad, busy_bad, done_cnt, err_cnt, both, pay_run;
    int exp_hdrs, exp_pay, exp_done, exp_code, k;
    bit acked, rd_active, fin, hdr_now;
    logic [1:0] code_seen;
    logic [7:0] hdr_sh, pay_sh, tmp;
    logic [7:0] pay_got[$];
    logic [7:0] rd_got[$];

    op = int'(h[7:6]);
    len = int'(h[2:0]) + 1;
    attempt = 0; in_wait = 0; wait_idx = 0; rs = 0; wr_idx = 0; hold = 0;
    hdr_run = 0; hdr_count = 0; hdr_bad = 0; ready_cnt = 0; ready_bad = 0;
    end_count = 0; bus_act = 0; oe_bad = 0; idle_bad = 0; busy_bad = 0;
    done_cnt = 0; err_cnt = 0; both = 0; pay_run = 0;
    rd_active = 1'b0; fin = 1'b0; code_seen = 2'b00;
    hdr_sh = '0; pay_sh = '0;
    stalls = 0;

    for (int cyc = 0; cyc < 500 && !fin; cyc++) begin
      @(negedge clk);
      if (rst_in_read && rd_active && rs == 5) begin
        rst = 1'b0;
        start = 1'b0;
        ack = 1'b0;
        #1;
        check("rst_busy_done_error", {busy, done, error}, 0);
        check("rst_err_code", err_code, 0);
        check("rst_ctrl_oe", {ctrl, data_oe}, 0);
        check("rst_data_out", data_out, 0);
        check("rst_wr_ready_rd_valid", {wr_ready, rd_valid}, 0);
        check("rst_rd_data", rd_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        return;
      end

      start = (cyc == 0) || (spur && $urandom_range(0, 5) == 0);
      header_in = (cyc == 0) ? h : 8'($urandom);
      acked = 1'b0;
      ack = 1'b0;
      if (in_wait != 0) begin
        d = (in_wait == 1) ? hack_dly[attempt] : dack_dly;
        if (wait_idx == d) begin
          ack = 1'b1;
          acked = 1'b1;
        end
      end else if (spur) begin
        ack = ($urandom_range(0, 3) == 0);
      end
      if (rd_active) begin
        tmp = rd_src[rs / B];
        data_in = tmp[7 - LANES * (rs % B) -: LANES];
      end else begin
        data_in = LANES'($urandom);
      end
      if (hold > 0) begin
        wr_valid = 1'b0;
        hold--;
      end else begin
        wr_valid = (wr_idx < wr_q.size());
      end
      wr_data = wr_valid ? wr_q[wr_idx] : 8'($urandom);

      #1;
      hdr_now = 1'b0;
      if (cyc >= 1 && busy !== 1'b1) busy_bad++;
      if (ctrl == 2'b01) begin
        if (data_oe !== 1'b1) oe_bad++;
        hdr_sh = (hdr_sh << LANES) | 8'(data_out);
        hdr_run++;
        if (hdr_run == B) begin
          hdr_count++;
          if (hdr_sh != h) hdr_bad++;
          hdr_run = 0;
          hdr_now = 1'b1;
        end
      end else begin
        hdr_run = 0;
      end
      if (ctrl == 2'b10) begin
        if (data_oe !== (op == 1)) oe_bad++;
        if (op == 1) begin
          pay_sh = (pay_sh << LANES) | 8'(data_out);
          pay_run++;
          if (pay_run == B) begin
            pay_got.push_back(pay_sh);
            pay_run = 0;
          end
        end
      end
      if (ctrl == 2'b11) end_count++;
      if (ctrl == 2'b00 && data_out !== '0) idle_bad++;
      if (ctrl != 2'b00 || data_oe) bus_act++;
      if (op == 1 && ctrl == 2'b00 && !wr_valid && pay_run == 0 && pay_got.size() > 0 &&
          pay_got.size() < len && ready_cnt == pay_got.size()) stalls++;
      if (rd_valid) rd_got.push_back(rd_data);
      if (wr_ready) begin
        if (!wr_valid) begin
          ready_bad++;
        end else begin
          ready_cnt++;
          wr_idx++;
          if (wr_idx == gap_byte) hold = B + gap_len;
          else if (rand_gap) hold = $urandom_range(0, B + 3);
        end
      end
      if (done) done_cnt++;
      if (error) begin
        err_cnt++;
        code_seen = err_code;
      end
      if (done && error) both++;
      if (done || error) fin = 1'b1;

      if (rd_active) begin
        rs++;
        if (rs == len * B) rd_active = 1'b0;
      end
      if (in_wait != 0) begin
        if (acked) begin
          if (in_wait == 1 && op == 2) begin
            rd_active = 1'b1;
            rs = 0;
          end
          in_wait = 0;
        end else if (wait_idx == ACK_TIMEOUT - 1) begin
          if (in_wait == 1) attempt++;
          in_wait = 0;
        end else begin
          wait_idx++;
        end
      end
      if (hdr_now) begin
        in_wait = 1;
        wait_idx = 0;
      end
      if (ctrl == 2'b11) begin
        in_wait = 2;
        wait_idx = 0;
      end
    end

    exp_hdrs = 0; exp_pay = 0; exp_done = 0; exp_code = 0;
    if (op == 0 || op == 3) begin
      exp_code = 3;
    end else if (len > MAX_BURST) begin
      exp_code = 2;
    end else begin
      k = 0;
      while (k <= MAX_RETRY && hack_dly[k] >= ACK_TIMEOUT) k++;
      if (k > MAX_RETRY) begin
        exp_hdrs = MAX_RETRY + 1;
        exp_code = 1;
      end else begin
        exp_hdrs = k + 1;
        exp_pay = 1;
        if (dack_dly >= ACK_TIMEOUT) exp_code = 1;
        else exp_done = 1;
      end
    end

    check("fin_reached", fin, 1);
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    #1;
    check("idle_after_fin", busy, 0);
    check("err_code_hold", err_code, exp_code);
    check("header_count", hdr_count, exp_hdrs);
    check("header_value_bad", hdr_bad, 0);
    check("oe_bad", oe_bad, 0);
    check("idle_data_nonzero", idle_bad, 0);
    check("busy_dropped", busy_bad, 0);
    check("done_and_error", both, 0);
    check("done_pulses", done_cnt, exp_done);
    check("error_pulses", err_cnt, (exp_done == 0) ? 1 : 0);
    if (exp_done == 0) check("err_code_fin", code_seen, exp_code);
    check("end_phases", end_count, exp_pay);
    check("wr_ready_without_valid", ready_bad, 0);
    if (exp_hdrs == 0) check("bus_activity", bus_act, 0);
    if (exp_pay != 0 && op == 1) begin
      check("wr_ready_count", ready_cnt, len);
      check("wr_byte_count", pay_got.size(), len);
      for (int i = 0; i < len && i < pay_got.size(); i++)
        check($sformatf("wr_byte%0d", i), pay_got[i], wr_q[i]);
    end else if (exp_pay != 0 && op == 2) begin
      check("rd_byte_count", rd_got.size(), len);
      for (int i = 0; i < len && i < rd_got.size(); i++)
        check($sformatf("rd_byte%0d", i), rd_got[i], rd_src[i]);
    end else begin
      check("wr_ready_count_none", ready_cnt, 0);
      check("rd_valid_count_none", rd_got.size(), 0);
    end
  endtask

  initial begin
    int st;
    logic [7:0] h;
    int r;

    rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_busy_done_error", {busy, done, error}, 0);
    check("reset_ctrl_oe_out", {ctrl, data_oe, data_out}, 0);
    check("reset_rd", {rd_valid, rd_data, wr_ready, err_code}, 0);
    @(negedge clk);
    rst = 1'b1;

    // One-byte write of A5: slices 10,10,01,01.
    setup(2, 2);
    wr_q[0] = 8'hA5;
    run_frame(8'b0100_0000, 1'b0, st);

    // Two-byte read 3C, F0.
    setup(2, 2);
    rd_src[0] = 8'h3C;
    rd_src[1] = 8'hF0;
    run_frame(8'b1000_0001, 1'b0, st);

    // Header never acked: 1 + MAX_RETRY headers then timeout error.
    setup(ACK_TIMEOUT + 10, 2);
    run_frame(8'b0100_0000, 1'b0, st);

    // Length and opcode rejects, plus the largest legal length.
    setup(2, 2);
    run_frame(8'b0100_0111, 1'b0, st);
    setup(2, 2);
    run_frame(8'b1000_0100, 1'b0, st);
    setup(1, 1);
    run_frame(8'b0101_1011, 1'b0, st);
    setup(2, 2);
    run_frame(8'b0000_0001, 1'b0, st);
    setup(2, 2);
    run_frame(8'b1100_0000, 1'b0, st);

    // Two-byte write with a 5-cycle source gap between bytes.
    setup(2, 2);
    gap_byte = 1;
    gap_len = 5;
    run_frame(8'b0100_0001, 1'b0, st);
    check("stall_cycles", st, 5);

    // Ack on the last cycle of the window is accepted; one cycle later is a timeout.
    setup(ACK_TIMEOUT - 1, ACK_TIMEOUT - 1);
    run_frame(8'b0100_0000, 1'b0, st);
    setup(0, 0);
    hack_dly[0] = ACK_TIMEOUT;
    run_frame(8'b1001_0000, 1'b0, st);
    setup(1, ACK_TIMEOUT);
    run_frame(8'b0100_0001, 1'b0, st);

    // Reset in the middle of a read, then a clean read.
    setup(1, 1);
    rd_src[0] = 8'h3C;
    rd_src[1] = 8'hF0;
    run_frame(8'b1000_0001, 1'b1, st);
    setup(1, 1);
    run_frame(8'b1000_0001, 1'b0, st);

    for (int n = 0; n < 40; n++) begin
      setup(0, 0);
      for (int i = 0; i < MAX_RETRY + 2; i++) hack_dly[i] = rand_dly();
      dack_dly = rand_dly();
      rand_gap = 1'b1;
      spur = 1'b1;
      h = 8'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0) h[7:6] = 2'b00;
      else if (r == 1) h[7:6] = 2'b11;
      else h[7:6] = r[0] ? 2'b01 : 2'b10;
      if ($urandom_range(0, 2) != 0) h[2:0] = 3'($urandom_range(0, MAX_BURST - 1));
      run_frame(h, 1'b0, st);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
